// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation datapath.
package rsa_pkg;

   // Default prime width of the key generator.
   localparam int DEF_WIDTH = 4;
   // Width of the modulus, exponent and data words.
   localparam int KW = 2 * DEF_WIDTH;
   // Width of the exponent-bit counter.
   localparam int CNT_W = $clog2(KW);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Combinational modular multiplier: r = (a * b) mod n, with r = 0 when n == 0.
module rsa_modmul #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] n,
   output logic [W-1:0] r
);

   logic [2*W-1:0] prod;
   logic [2*W-1:0] n_ext;

   // Full double-width product, then reduction; a zero modulus is defined to give 0.
   always_comb begin
      prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      n_ext = {{W{1'b0}}, n};
      if (n == '0) begin
         r = '0;
      end else begin
         r = W'(prod % n_ext);
      end
   end

endmodule

// File: rtl/rsa_modexp_engine.sv
// Right-to-left square-and-multiply modular exponentiation, one exponent bit
// per cycle, fixed latency of 2*WIDTH cycles, valid/ready request handshake.
module rsa_modexp_engine
   import rsa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   in_n,
   input  logic [2*WIDTH-1:0]   in_exp,
   input  logic [2*WIDTH-1:0]   in_data,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   out_data
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW);

   state_t         state;
   logic [DW-1:0]  acc;
   logic [DW-1:0]  base;
   logic [DW-1:0]  exp_sh;
   logic [DW-1:0]  n_r;
   logic [CW-1:0]  cnt;

   logic [DW-1:0]  acc_next;
   logic [DW-1:0]  sq_a;
   logic [DW-1:0]  sq_b;
   logic [DW-1:0]  sq_n;
   logic [DW-1:0]  sq_r;

   // Squaring multiplier operands; in IDLE it is borrowed to reduce in_data mod in_n.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      sq_a = base;
      sq_b = base;
      sq_n = n_r;
      if (state == IDLE) begin
         sq_a = in_data;
         sq_b = DW'(1);
         sq_n = in_n;
      end
   end

   rsa_modmul #(.W(DW)) u_mul_acc (
      .a (acc),
      .b (base),
      .n (n_r),
      .r (acc_next)
   );

   rsa_modmul #(.W(DW)) u_mul_sq (
      .a (sq_a),
      .b (sq_b),
      .n (sq_n),
      .r (sq_r)
   );

   // Control FSM and datapath registers; all outputs are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: datapath registers are reset too, so a reset mid-run leaves no stale X-free-but-wrong state behind.
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         acc       <= '0;
         base      <= '0;
         exp_sh    <= '0;
         n_r       <= '0;
         cnt       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (in_valid) begin
                  n_r      <= in_n;
                  exp_sh   <= in_exp;
                  base     <= sq_r;
                  acc      <= (in_n > DW'(1)) ? DW'(1) : '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (exp_sh[0]) begin
                  acc <= acc_next;
               end
               base   <= sq_r;
               exp_sh <= exp_sh >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(DW - 1)) begin
                  out_data  <= exp_sh[0] ? acc_next : acc;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Self-checking bench for rsa_modexp_engine with a pow-mod reference model.
module tb_rsa_modexp_engine;

   localparam int W   = 4;
   localparam int DW  = 2 * W;
   localparam int LAT = DW;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_n;
   logic [DW-1:0] in_exp;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic [DW-1:0] out_data;

   int n_checks = 0;
   int n_fails  = 0;

   rsa_modexp_engine #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_n      (in_n),
      .in_exp    (in_exp),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: data^exp mod n by repeated multiplication; mod 0 is defined as 0.
   function automatic logic [DW-1:0] pow_mod(input int unsigned n, input int unsigned e,
                                             input int unsigned d);
      longint unsigned r;
      if (n == 0) return '0;
      r = 1 % n;
      for (int i = 0; i < e; i++) r = (r * d) % n;
      return DW'(r);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Present one request at a negedge; returns #1 after the accepting edge with in_valid low
   // and the data inputs scrambled to show they are not resampled during CALC.
   task automatic send(input string tag, input logic [DW-1:0] n, input logic [DW-1:0] e,
                       input logic [DW-1:0] d);
      @(negedge clk);
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_n     = n;
      in_exp   = e;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_n     = DW'($urandom);
      in_exp   = DW'($urandom);
      in_data  = DW'($urandom);
   endtask

   // Count edges to the next out_valid, check latency and value, then pulse width and in_ready.
   task automatic wait_result(input string tag, input logic [DW-1:0] expv, input int exp_lat);
      int lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 40);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_data"}, 32'(out_data), 32'(expv));
      @(posedge clk);
      #1;
      check({tag, "_pulse1"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [DW-1:0] rn, re, rd;
      int lat;
      bit pulsed;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_n     = '0;
      in_exp   = '0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors from the key generator's n=33 key pair and degenerate moduli.
      send("decrypt", 8'd33, 8'd7, 8'd31);   wait_result("decrypt", 8'd4, LAT);
      send("encrypt", 8'd33, 8'd3, 8'd4);    wait_result("encrypt", 8'd31, LAT);
      send("reduce", 8'd33, 8'd1, 8'd40);    wait_result("reduce", 8'd7, LAT);
      send("midrun", 8'd33, 8'd3, 8'd2);     wait_result("midrun", 8'd8, LAT);
      send("exp0", 8'd33, 8'd0, 8'd17);      wait_result("exp0", 8'd1, LAT);
      send("n1", 8'd1, 8'd5, 8'd9);          wait_result("n1", 8'd0, LAT);
      send("n0", 8'd0, 8'd5, 8'd9);          wait_result("n0", 8'd0, LAT);

      // in_valid held high: new inputs during CALC are ignored, next request 10 edges later.
      @(negedge clk);
      in_valid = 1'b1;
      in_n     = 8'd33;
      in_exp   = 8'd7;
      in_data  = 8'd31;
      @(posedge clk);
      #1;
      in_exp  = 8'd3;
      in_data = 8'd4;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 40);
      check("hold_first_lat", 32'(lat), 32'(LAT));
      check("hold_first_data", 32'(out_data), 32'd4);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 5) check("hold_out_data", 32'(out_data), 32'd4);
      end while (!out_valid && lat < 40);
      in_valid = 1'b0;
      check("b2b_spacing", 32'(lat), 32'(LAT + 2));
      check("b2b_data", 32'(out_data), 32'd31);
      repeat (2) @(posedge clk);
      #1;
      check("b2b_idle_ready", 32'(in_ready), 32'd1);

      // Reset during CALC discards the pending result.
      send("rstcalc", 8'd33, 8'd7, 8'd31);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rstcalc_out_valid", 32'(out_valid), 32'd0);
      check("rstcalc_in_ready", 32'(in_ready), 32'd1);
      check("rstcalc_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulsed = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) pulsed = 1'b1;
      end
      check("rstcalc_no_pulse", 32'(pulsed), 32'd0);
      check("rstcalc_ready_after", 32'(in_ready), 32'd1);

      // Random sweep against the reference model.
      for (int k = 0; k < 24; k++) begin
         rn = DW'($urandom_range(0, 255));
         re = DW'($urandom);
         rd = DW'($urandom);
         send($sformatf("rand%0d", k), rn, re, rd);
         wait_result($sformatf("rand%0d", k), pow_mod(rn, re, rd), LAT);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
